// File: rtl/i2c_pkg.sv
// i2c_pkg: FSM state encoding and bit count shared by the I2C target files.
package i2c_pkg;
  localparam logic [3:0] BITS = 4'd8;
  typedef logic [3:0] state_t;
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] ADDR     = 4'd1;
  localparam logic [3:0] ACK_ADDR = 4'd2;
  localparam logic [3:0] REG_PTR  = 4'd3;
  localparam logic [3:0] ACK_PTR  = 4'd4;
  localparam logic [3:0] WRITE    = 4'd5;
  localparam logic [3:0] ACK_DATA = 4'd6;
  localparam logic [3:0] READ     = 4'd7;
  localparam logic [3:0] RACK     = 4'd8;
  localparam logic [3:0] IGNORE   = 4'd9;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: SCL/SDA synchronizers plus edge, START and STOP detection.
module i2c_bus_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);
  // [0],[1] are the synchronizer, [2] is the history flop
  logic [2:0] scl_q, sda_q;
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], i_scl};
      sda_q <= {sda_q[1:0], i_sda};
    end
  assign o_sda      = sda_q[1];
  assign o_scl_rise = scl_q[1] & ~scl_q[2];
  assign o_scl_fall = ~scl_q[1] & scl_q[2];
  assign o_start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign o_stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target with a fixed device address, register pointer byte and register-file port.
// Define I2C_TARGET_AUTOINC_EN to advance the pointer after every written or ACKed read byte.
module i2c_target
  import i2c_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int REG_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] DEV_ADDR = 7'h42
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_scl,
  input  logic                  i_sda,
  output logic                  o_sda_oe,
  output logic [REG_WIDTH-1:0]  o_reg_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_wr_en,
  output logic                  o_rd_en,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_busy
);
`ifdef I2C_TARGET_AUTOINC_EN
  localparam logic [REG_WIDTH-1:0] PTR_INC = REG_WIDTH'(1);
`else
  localparam logic [REG_WIDTH-1:0] PTR_INC = '0;
`endif
  logic scl_rise, scl_fall, start, stop, sda, last, match;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, byte_in;
  logic oe_q, oe_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d, busy_q, busy_d, rw_q, rw_d, ld_q;
  logic [REG_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  i2c_bus_sync u_sync (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_scl(i_scl),
    .i_sda(i_sda),
    .o_sda(sda),
    .o_scl_rise(scl_rise),
    .o_scl_fall(scl_fall),
    .o_start(start),
    .o_stop(stop)
  );
  assign byte_in = {shift_q[6:0], sda};
  assign last    = cnt_q == BITS - 4'd1;
  assign match   = byte_in[7 -: ADDR_WIDTH] == DEV_ADDR;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = ld_q ? i_rd_data : shift_q;
    oe_d       = oe_q;
    reg_addr_d = wr_en_q ? reg_addr_q + PTR_INC : reg_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;
    if (stop) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR, REG_PTR, WRITE: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = last ? 4'd0 : cnt_q + 4'd1;
          if (last && state_q == ADDR) begin
            rw_d    = sda;
            state_d = match ? ACK_ADDR : IGNORE;
            busy_d  = match;
            rd_en_d = match & sda;
          end else if (last && state_q == REG_PTR) begin
            reg_addr_d = REG_WIDTH'(byte_in);
            state_d    = ACK_PTR;
          end else if (last) begin
            wr_data_d = DATA_WIDTH'(byte_in);
            wr_en_d   = 1'b1;
            state_d   = ACK_DATA;
          end
        end
        // first fall starts the ACK pulse, second fall ends the ACK slot
        ACK_ADDR, ACK_PTR, ACK_DATA: if (scl_fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else if (state_q == ACK_ADDR && rw_q) begin
            oe_d    = ~shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = 4'd1;
            state_d = READ;
          end else begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = state_q == ACK_ADDR ? REG_PTR : WRITE;
          end
        end
        READ: if (scl_fall) begin
          oe_d    = cnt_q == BITS ? 1'b0 : ~shift_q[7];
          shift_d = {shift_q[6:0], 1'b0};
          cnt_d   = cnt_q == BITS ? 4'd0 : cnt_q + 4'd1;
          state_d = cnt_q == BITS ? RACK : READ;
        end
        RACK: if (scl_rise) begin
          state_d    = sda ? IGNORE : READ;
          rd_en_d    = ~sda;
          reg_addr_d = sda ? reg_addr_q : reg_addr_q + PTR_INC;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      oe_q       <= 1'b0;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      ld_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      oe_q       <= oe_d;
      reg_addr_q <= reg_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      ld_q       <= rd_en_q;
    end
  assign o_sda_oe   = oe_q;
  assign o_reg_addr = reg_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_wr_en    = wr_en_q;
  assign o_rd_en    = rd_en_q;
  assign o_busy     = busy_q;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C controller driving random transactions against a register-file model.
module tb_i2c_target;
`ifdef I2C_TARGET_AUTOINC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif
  localparam int Q = 5;
  logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_sda = 1'b1, sda;
  logic sda_oe, wr_en, rd_en, busy;
  logic [7:0] reg_addr, wr_data, rd_data = 8'h00;
  logic [7:0] regs [256];
  logic [7:0] ref_mem [256];
  logic [15:0] wr_log [$];
  int n_vec = 0, n_err = 0, rd_cnt = 0, busy_seen = 0, oe_seen = 0, hold = 0;
  assign sda = m_sda & ~sda_oe;
  always #5 clk = ~clk;
  i2c_target dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_scl(scl),
    .i_sda(sda),
    .o_sda_oe(sda_oe),
    .o_reg_addr(reg_addr),
    .o_wr_data(wr_data),
    .o_wr_en(wr_en),
    .o_rd_en(rd_en),
    .i_rd_data(rd_data),
    .o_busy(busy)
  );
  // on-chip register file seen by the target; read data is only held long enough to be latched
  always @(negedge clk) begin
    if (wr_en) begin
      wr_log.push_back({reg_addr, wr_data});
      regs[reg_addr] = wr_data;
    end
    if (rd_en) begin
      rd_cnt++;
      rd_data = regs[reg_addr];
      hold = 2;
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) rd_data = 8'($urandom);
    end
    if (busy) busy_seen++;
    if (sda_oe) oe_seen++;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic put_bit(input logic b);
    wait_clk(Q); m_sda = b; wait_clk(Q); scl = 1'b1; wait_clk(2 * Q); scl = 1'b0;
  endtask
  task automatic get_bit(output logic b);
    wait_clk(Q); m_sda = 1'b1; wait_clk(Q); scl = 1'b1; wait_clk(Q); b = sda; wait_clk(Q); scl = 1'b0;
  endtask
  task automatic bus_start;
    wait_clk(Q); m_sda = 1'b1; wait_clk(Q); scl = 1'b1; wait_clk(Q); m_sda = 1'b0; wait_clk(Q); scl = 1'b0;
  endtask
  task automatic bus_stop;
    wait_clk(Q); m_sda = 1'b0; wait_clk(Q); scl = 1'b1; wait_clk(Q); m_sda = 1'b1; wait_clk(2 * Q);
  endtask
  task automatic put_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(ack);
  endtask
  task automatic get_byte(output logic [7:0] b, input logic ack);
    logic t;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      get_bit(t);
      b = {b[6:0], t};
    end
    put_bit(ack);
  endtask
  task automatic xfer_write(input logic [6:0] a, input logic [7:0] ptr, input int n,
                            input logic [7:0] d [4], output logic [5:0] acks);
    logic ak;
    acks = '0;
    bus_start;
    put_byte({a, 1'b0}, ak); acks[0] = ak;
    put_byte(ptr, ak); acks[1] = ak;
    for (int k = 0; k < n; k++) begin
      put_byte(d[k], ak);
      acks[k + 2] = ak;
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    wait_clk(3);
    n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
    n_vec++; if (reg_addr !== 8'h00) begin n_err++; $display("FAIL reset_reg_addr got %h want 00", reg_addr); end
    n_vec++; if (wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
    n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    n_vec++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    wait_clk(3);
  endtask
  task automatic test_write(input logic [7:0] ptr, input int n, input logic [7:0] d [4]);
    logic [5:0] acks;
    logic [15:0] want;
    wr_log.delete();
    xfer_write(7'h42, ptr, n, d, acks);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL write_busy got %b want 1", busy); end
    bus_stop;
    for (int k = 0; k < n + 2; k++) begin
      n_vec++; if (acks[k] !== 1'b0) begin n_err++; $display("FAIL write_ack slot %0d got %b want 0", k, acks[k]); end
    end
    n_vec++; if (wr_log.size() != n) begin n_err++; $display("FAIL write_count got %0d want %0d", wr_log.size(), n); end
    for (int k = 0; k < n; k++) begin
      want = {8'(ptr + k * INC), d[k]};
      ref_mem[want[15:8]] = d[k];
      if (k < wr_log.size()) begin
        n_vec++; if (wr_log[k] !== want) begin n_err++; $display("FAIL write_strobe %0d got addr/data %h want %h", k, wr_log[k], want); end
      end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL write_busy_after_stop got %b want 0", busy); end
  endtask
  task automatic test_read(input logic [7:0] ptr, input int n);
    logic [5:0] acks;
    logic [7:0] none [4];
    logic [7:0] b, want;
    logic ak;
    int rd0;
    none = '{8'h00, 8'h00, 8'h00, 8'h00};
    xfer_write(7'h42, ptr, 0, none, acks);
    rd0 = rd_cnt;
    bus_start;
    put_byte({7'h42, 1'b1}, ak);
    for (int k = 0; k < n; k++) begin
      get_byte(b, k == n - 1);
      want = ref_mem[8'(ptr + k * INC)];
      n_vec++; if (b !== want) begin n_err++; $display("FAIL read_byte %0d ptr %h got %h want %h", k, ptr, b, want); end
    end
    n_vec++; if ({acks[1:0], ak} !== 3'b000) begin n_err++; $display("FAIL read_acks got %b want 000", {acks[1:0], ak}); end
    n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL read_release got %b want 0", sda_oe); end
    n_vec++; if (rd_cnt - rd0 != n) begin n_err++; $display("FAIL read_rd_en_count got %0d want %0d", rd_cnt - rd0, n); end
    bus_stop;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL read_busy_after_stop got %b want 0", busy); end
  endtask
  task automatic test_wrong_addr(input logic [6:0] a);
    logic [5:0] acks;
    logic [7:0] d [4];
    int rd0;
    for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
    wr_log.delete();
    busy_seen = 0;
    oe_seen = 0;
    rd0 = rd_cnt;
    xfer_write(a, 8'($urandom), 2, d, acks);
    bus_stop;
    n_vec++; if (acks[3:0] !== 4'b1111) begin n_err++; $display("FAIL wrong_addr_acks addr %h got %b want 1111", a, acks[3:0]); end
    n_vec++; if (wr_log.size() != 0) begin n_err++; $display("FAIL wrong_addr_wr_en got %0d want 0", wr_log.size()); end
    n_vec++; if (busy_seen != 0 || oe_seen != 0 || rd_cnt != rd0) begin
      n_err++; $display("FAIL wrong_addr_activity got busy %0d oe %0d rd %0d want 0 0 0", busy_seen, oe_seen, rd_cnt - rd0);
    end
  endtask
  task automatic test_stop_mid;
    logic ak;
    wr_log.delete();
    bus_start;
    put_byte({7'h42, 1'b0}, ak);
    put_byte(8'($urandom), ak);
    for (int i = 0; i < 4; i++) put_bit(1'($urandom));
    bus_stop;
    n_vec++; if (wr_log.size() != 0) begin n_err++; $display("FAIL stop_mid_wr_en got %0d want 0", wr_log.size()); end
    n_vec++; if (busy !== 1'b0 || sda_oe !== 1'b0) begin n_err++; $display("FAIL stop_mid_idle got busy %b oe %b want 0 0", busy, sda_oe); end
  endtask
  task automatic test_reset_mid_read;
    logic [5:0] acks;
    logic [7:0] none [4];
    logic [7:0] ptr;
    logic ak, t;
    none = '{8'h00, 8'h00, 8'h00, 8'h00};
    ptr = 8'($urandom);
    regs[ptr] = 8'h00;
    ref_mem[ptr] = 8'h00;
    xfer_write(7'h42, ptr, 0, none, acks);
    bus_start;
    put_byte({7'h42, 1'b1}, ak);
    for (int i = 0; i < 3; i++) get_bit(t);
    wait_clk(4);
    n_vec++; if (sda_oe !== 1'b1) begin n_err++; $display("FAIL mid_read_drive got %b want 1", sda_oe); end
    rst_n = 1'b0;
    wait_clk(1);
    n_vec++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_read_reset got oe %b busy %b want 0 0", sda_oe, busy); end
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(2);
    bus_stop;
  endtask
  task automatic test_back_to_back(input int iters);
    logic [7:0] d [4];
    for (int i = 0; i < iters; i++) begin
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      test_write(8'($urandom), $urandom_range(1, 3), d);
      test_read(8'($urandom), $urandom_range(1, 3));
    end
  endtask
  initial begin
    logic [7:0] dv [4];
    logic [6:0] a;
    for (int i = 0; i < 256; i++) begin
      regs[i] = 8'($urandom);
      ref_mem[i] = regs[i];
    end
    test_reset;
    dv = '{8'hA5, 8'h00, 8'h00, 8'h00};
    test_write(8'h10, 1, dv);
    regs[8'h20] = 8'h3C;
    ref_mem[8'h20] = 8'h3C;
    test_read(8'h20, 1);
    test_wrong_addr(7'h43);
    dv = '{8'h11, 8'h22, 8'h00, 8'h00};
    test_write(8'hFF, 2, dv);
    test_read(8'hFF, 2);
    test_stop_mid;
    test_back_to_back(4);
    a = 7'($urandom);
    if (a == 7'h42) a = 7'h17;
    test_wrong_addr(a);
    test_reset_mid_read;
    test_back_to_back(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
